huffman_bit_packer: RTL
=======================

HUFFMAN_BIT_PACKER -- requirements
Module: huffman_bit_packer

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge system clock.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-003 SHALL have port code_in, input, 10, Huffman code; significant bits are code_in[code_len-1:0], right-aligned.
REQ-004 SHALL have port code_len, input, 4, code length in bits; valid range 0..10.
REQ-005 SHALL have port code_valid, input, 1, upstream code and length are valid.
REQ-006 SHALL have port code_ready, output, 1, block can accept a code this cycle.
REQ-007 SHALL have port code_ack, output, 1, one-cycle pulse in the cycle after a code is accepted; usable as the upstream load pulse.
REQ-008 SHALL have port flush, input, 1, request to pad and emit the remaining partial byte.
REQ-009 SHALL have port byte_out, output, 8, packed byte; first-emitted bit in byte_out[7].
REQ-010 SHALL have port byte_valid, output, 1, byte_out is valid.
REQ-011 SHALL have port byte_ready, input, 1, downstream accepts byte_out.
REQ-012 SHALL have port flush_done, output, 1, one-cycle pulse when a flush has completed.
REQ-013 SHALL have port byte_count, output, 16, number of bytes transferred since reset.

Function
REQ-014 SHALL keep a 17-bit left-aligned accumulator acc and a 5-bit fill count (0..17); valid bits are acc[16:17-fill].
REQ-015 SHALL drive code_ready = 1 only in state RUN with fill <= 7 and flush low.
REQ-016 SHALL accept a code on a rising clk edge with code_valid && code_ready: append code_in[len-1:0] MSB-first directly after the valid bits, and set fill += len.
REQ-017 SHALL clamp code_len values 11..15 to 10, and accept code_len 0 with no change to acc or fill; code_ack still pulses.
REQ-018 SHALL drive byte_valid = 1 whenever fill >= 8, with byte_out = acc[16:9].
REQ-019 SHALL, on byte_valid && byte_ready, shift acc left by 8 with zero fill, set fill -= 8, and increment byte_count, which wraps from 0xFFFF to 0.
REQ-020 SHALL keep byte_out and byte_valid stable while byte_valid && !byte_ready.
REQ-021 SHALL never accept a code and pop a byte in the same cycle; this follows from REQ-015 and REQ-018.
REQ-022 SHALL implement FSM states RUN, FLUSH and DONE; reset enters RUN.
REQ-023 SHALL, in RUN with flush high, move to FLUSH; a code_valid in that same cycle is not accepted.
REQ-024 SHALL, in FLUSH, hold code_ready low and first drain all full bytes per REQ-018/019.
REQ-025 SHALL, in FLUSH with 1 <= fill <= 7, drive byte_valid = 1 and byte_out = acc[16:9] with the unused low bits zero.
REQ-026 SHALL, on that padded-byte handshake, set fill = 0 and acc = 0, increment byte_count, and move to DONE.
REQ-027 SHALL, in FLUSH with fill = 0, move to DONE on the next edge without emitting a byte.
REQ-028 SHALL, in DONE, assert flush_done for exactly one cycle, then return to RUN; code_ready is low in DONE.
REQ-029 SHALL ignore flush while in FLUSH or DONE.

Reset
REQ-030 SHALL, while reset is high, asynchronously force acc=0, fill=0, state=RUN, byte_out=0x00, byte_valid=0, code_ready=0, code_ack=0, flush_done=0 and byte_count=0.
REQ-031 SHALL discard all partial data if reset is asserted mid-operation, including mid-flush; no byte is emitted after reset.

Verification
REQ-032 SHALL pass: after reset, codes (0b101,3), (0b11110,5) and byte_ready=1 -> one byte 0xBE, fill=0, byte_count=1.
REQ-033 SHALL pass: code (0x3FF,10) then (0x000,6) -> bytes 0xFF then 0xC0, fill=0.
REQ-034 SHALL pass: code (0b1,1) then flush -> byte 0x80 (padded), flush_done pulses once, byte_count=1.
REQ-035 SHALL pass: with byte_ready held low and fill=12 -> byte_valid=1, byte_out stable, code_ready=0 until byte_ready rises.
REQ-036 SHALL pass: flush at fill=0 -> no byte, flush_done pulses two cycles after flush; code_len=0 -> code_ack pulses, fill unchanged.
REQ-037 SHALL pass: reset asserted during FLUSH with fill=5 -> all outputs at reset values, and no byte_valid after reset deasserts until new codes arrive.

Source files
------------

// File: rtl/huffman_bit_packer.sv
// huffman_bit_packer: packs variable-length Huffman codes MSB-first into bytes, with flush-to-byte padding
module huffman_bit_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  code_in,
  input  logic [3:0]  code_len,
  input  logic        code_valid,
  output logic        code_ready,
  output logic        code_ack,
  input  logic        flush,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        flush_done,
  output logic [15:0] byte_count
);
  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;
  state_t state, state_nx;
  logic [16:0] acc, acc_nx;
  logic [4:0] fill, fill_nx;
  logic [3:0] len;
  logic [9:0] bits;
  logic accept, pop, full;
  always_comb begin
    len = code_len > 4'd10 ? 4'd10 : code_len;
    bits = code_in & ~(10'h3ff << len);
    full = fill >= 5'd8;
    code_ready = !reset && state == RUN && !full && !flush;
    byte_valid = full || (state == FLUSH && fill != 5'd0);
    byte_out = acc[16:9];
    flush_done = state == DONE;
    accept = code_valid && code_ready;
    pop = byte_valid && byte_ready;
    acc_nx = acc;
    fill_nx = fill;
    if (accept) begin
      acc_nx = acc | ({7'd0, bits} << (5'd17 - fill - {1'b0, len}));
      fill_nx = fill + {1'b0, len};
    end
    if (pop) begin
      acc_nx = full ? acc << 8 : '0;
      fill_nx = full ? fill - 5'd8 : 5'd0;
    end
    state_nx = state == RUN ? (flush ? FLUSH : RUN) :
               state == DONE ? RUN :
               (fill == 5'd0 || (pop && !full)) ? DONE : FLUSH;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= RUN;
      acc <= '0;
      fill <= '0;
      code_ack <= 1'b0;
      byte_count <= '0;
    end else begin
      state <= state_nx;
      acc <= acc_nx;
      fill <= fill_nx;
      code_ack <= accept;
      if (pop) byte_count <= byte_count + 16'd1;
    end
endmodule
